// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and rcon lookup.
// Used by the key-expand engine, its interface and the SubWord block.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } ke_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in handshake, round-key stream and store read port.
// slave = key-expand engine, master = key source / round datapath.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic                 key_valid;
  logic                 key_ready;
  logic [AES_KEY_W-1:0] key_in;
  logic                 rk_valid;
  logic [AES_KEY_W-1:0] rk_data;
  logic [3:0]           rk_round;
  logic                 done;
  logic                 busy;
  logic [3:0]           rk_rd_idx;
  logic [AES_KEY_W-1:0] rk_rd_data;

  modport slave (
    input  key_valid, key_in, rk_rd_idx,
    output key_ready, rk_valid, rk_data, rk_round,
    output done, busy, rk_rd_data
  );

  modport master (
    output key_valid, key_in, rk_rd_idx,
    input  key_ready, rk_valid, rk_data, rk_round,
    input  done, busy, rk_rd_data
  );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four byte S-boxes applied to a 32-bit word.
// S-box is GF(2^8) inverse (x^254) followed by the AES affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse as product of x^2..x^128, then affine transform
  always_comb begin
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
          ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end

endmodule

module aes_sub_word
  import aes_pkg::*;
(
  input  word_t w,
  output word_t s
);

  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sbox (
      .a (w[8*g +: 8]),
      .s (s[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule, one round key per clock.
// Optional round-key store: define AES_KEY_STORE_EN.
module aes_key_expand
  import aes_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  aes_key_expand_if.slave bus
);

  ke_state_e            state_q, state_d;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_KEY_W-1:0] next_key;
  logic [3:0]           round_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 last;
  logic                 accept;
  logic                 step;
  word_t                w0, w1, w2, w3;
  word_t                sw, t;
  word_t                n0, n1, n2, n3;

  assign last   = (round_q == 4'(AES_NR));
  assign accept = (state_q == IDLE) && bus.key_valid;
  assign step   = (state_q == EXPAND) && !last;

  assign {w0, w1, w2, w3} = key_q;

  aes_sub_word u_sub_word (
    .w (word_t'({w3[23:0], w3[31:24]})),
    .s (sw)
  );

  assign t        = sw ^ {rcon(round_q), 24'h0};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d       = state_q;
    bus.key_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) state_d = EXPAND;
      end
      EXPAND: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // round-key datapath: load key, then one round per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      key_q   <= bus.key_in;
      round_q <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (step) begin
      key_q   <= next_key;
      round_q <= round_q + 4'd1;
      done_q  <= (round_q == 4'(AES_NR - 1));
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end
  end

  assign bus.rk_data  = key_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == EXPAND);

`ifdef AES_KEY_STORE_EN
  logic [AES_KEY_W-1:0] store [0:AES_NR];

  // capture each round key on the edge that loads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= AES_NR; i++) store[i] <= '0;
    end else if (accept) begin
      store[0] <= bus.key_in;
    end else if (step) begin
      store[round_q + 4'd1] <= next_key;
    end
  end

  assign bus.rk_rd_data = (bus.rk_rd_idx <= 4'(AES_NR))
                        ? store[bus.rk_rd_idx] : '0;
`else
  assign bus.rk_rd_data = '0;
`endif

endmodule
